m3_round_len_calc: RTL and testbench
====================================

# m3_round_len_calc

Step-period calculator for motor channel 3. It answers the step sequencer's per-round calculation request by producing the next step length, `dstRoundLen`. The length ramps toward a target period set by the speed buttons. The block also holds the power level. It sits between the button/command decode and the step sequencer, and drives the sequencer's `dstRoundLenI`.

## Interface
Parameters:
- PERIOD_MIN, 22'd1000: shortest step period (fastest speed), in clocks.
- PERIOD_MAX, 22'd4_000_000: longest step period; also the stopped/idle period.
- TGT_STEP, 22'd100_000: target change per speed button pulse.
- RAMP_SHIFT, 3: ramp divisor exponent.
- PWR_RESET, 4'd8: power level after reset.

Ports:
- clkI  in  1  single clock.
- rstI  in  1  reset; **synchronous, active-high**.
- m3startI  in  1  level; channel enabled.
- m3forceStopI  in  1  level; decelerate to PERIOD_MAX.
- m3speedINCi / m3speedDECi  in  1  one-cycle pulses; speed up / slow down.
- m3powerINCi / m3powerDECi  in  1  one-cycle pulses.
- nextCalc_1i  in  1  sequencer request; a level that stays high for a whole step.
- dstRoundLenO  out  32  next step length; zero-extended 22-bit value.
- powerLevelO  out  4  power level, 0..15.
- calcBusyO  out  1  high in CALC or APPLY.
- atTargetO  out  1  current period equals target period.
- stoppedO  out  1  forceStop active and current period equals PERIOD_MAX.

## Operation
- Internal registers, all 22 bits: `cur` (current period) and `tgt` (target period). `reqD` holds the delayed nextCalc_1i.
- Request is the rising edge: `nextCalc_1i & ~reqD`.
- FSM states:
  - IDLE: m3startI low. Go to WAIT on m3startI high.
  - WAIT: on request, go to CALC.
  - CALC: latch `diff = |cur - tgt|` and the direction. Set `delta = diff >> RAMP_SHIFT`; if `delta == 0` and `diff != 0`, force `delta = 1`.
  - APPLY: move `cur` toward `tgt` by `delta`. Never overshoot; clamp to [PERIOD_MIN, PERIOD_MAX]. Return to WAIT.
- m3startI low in any state:
  - Go to IDLE next cycle.
  - `cur <= PERIOD_MAX`; `tgt` is kept.
  - A request in flight is discarded.
- Speed pulses:
  - INC: `tgt -= TGT_STEP`, saturating at PERIOD_MIN.
  - DEC: `tgt += TGT_STEP`, saturating at PERIOD_MAX.
  - INC and DEC in the same cycle: no change.
- Power pulses: same scheme, saturating at 0 and 15; INC and DEC in the same cycle means no change. Power is active in every state.
- m3forceStopI high:
  - The ramp uses PERIOD_MAX as the effective target.
  - Speed pulses are ignored.
  - `tgt` is held unchanged and resumes when forceStop drops.
- A `tgt` change during CALC/APPLY affects the next request only.
- A request edge during CALC/APPLY is ignored. It is unreachable in normal use.
- dstRoundLenO changes only at the end of APPLY, or when m3startI is low (then it shows PERIOD_MAX).

## Timing
- Reset values:
  - dstRoundLenO = PERIOD_MAX; `cur` = `tgt` = PERIOD_MAX.
  - powerLevelO = PWR_RESET; calcBusyO = 0; atTargetO = 1; stoppedO = 0.
  - FSM = IDLE; `reqD` = 0.
- Latency: edge sampled at cycle N → CALC at N+1 → APPLY at N+2 → new dstRoundLenO visible from N+3.
- The 3-cycle latency is far below PERIOD_MIN, so the value is stable before the sequencer reloads.
- Button pulses take effect on `tgt` the next cycle.
- atTargetO and stoppedO are registered. They update the cycle after `cur`/`tgt` change.

## Structure
- Shared include `motor602_rtl_top.def.inc.v` holds:
  - FSM state encodings (IDLE/WAIT/CALC/APPLY).
  - The 22-bit period width macro.
  - The PERIOD_MAX default, which equals the existing `eachSlicePeriodMax`.
- One natural sub-module, `m3_ramp_step`: registered |diff|/shift/min-1 unit with clamping, instantiated once.
- The FSM, button logic and edge detect live in the top.

## Test plan
- Reset with start high → dstRoundLenO = 4_000_000, powerLevelO = 8, atTargetO = 1; requests leave the output unchanged.
- One speedINC, then a request edge → `tgt` = 3_900_000; dstRoundLenO = 3_987_500 three cycles after the edge; calcBusyO high for 2 cycles.
- 45 speedINC pulses → `tgt` saturates at 1000. Repeated requests converge monotonically with no overshoot, and the final steps are delta = 1. atTargetO rises when `cur` = 1000.
- At `cur` = 1000, raise forceStop → `cur` ramps back to 4_000_000, then stoppedO = 1. Speed pulses during the ramp leave `tgt` = 1000. Dropping forceStop resumes the ramp toward 1000.
- Power: 10 powerINC → 15 (saturates). INC and DEC in the same cycle → unchanged. 20 powerDEC → 0.
- Drop m3startI between the edge and APPLY → the output returns to 4_000_000 and no update lands. A long nextCalc_1i level produces exactly one calculation. A synchronous rstI mid-ramp restores all reset values the next cycle.

Source files
------------

// File: rtl/m3_round_len_calc_pkg.sv
// Shared types and defaults for the motor channel 3 step-period calculator.
// Holds FSM encodings, the period width and the idle period default.
package m3_round_len_calc_pkg;

  localparam int PW = 22;

  typedef logic [PW-1:0] period_t;

  localparam period_t PERIOD_MAX_DEF = 22'd4_000_000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CALC  = 2'd2,
    S_APPLY = 2'd3
  } state_e;

  function automatic period_t clamp_p(
    input logic [PW:0] v,
    input period_t     lo,
    input period_t     hi
  );
    period_t r;
    if (v < {1'b0, lo})
      r = lo;
    else if (v > {1'b0, hi})
      r = hi;
    else
      r = v[PW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/m3_round_len_calc_ramp.sv
// Ramp step unit: latches |cur - tgt| >> shift (min 1) and direction,
// then offers the clamped next period computed from that latched step.
module m3_ramp_step
  import m3_round_len_calc_pkg::*;
#(
  parameter period_t     PERIOD_MIN = 22'd1000,
  parameter period_t     PERIOD_MAX = PERIOD_MAX_DEF,
  parameter int unsigned RAMP_SHIFT = 3
) (
  input  logic      clkI,
  input  logic      rstI,
  input  logic      latchI,
  input  period_t   curI,
  input  period_t   tgtI,
  output period_t   nextO
);

  period_t    delta_q, delta_d;
  logic       dn_q, dn_d;
  period_t    diff;
  logic [PW:0] sum;

  always_comb begin
    delta_d = delta_q;
    dn_d    = dn_q;
    diff    = (curI >= tgtI) ? (curI - tgtI) : (tgtI - curI);
    if (latchI) begin
      dn_d    = curI > tgtI;
      delta_d = diff >> RAMP_SHIFT;
      if (delta_d == '0 && diff != '0)
        delta_d = 22'd1;
    end
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      delta_q <= '0;
      dn_q    <= 1'b0;
    end else begin
      delta_q <= delta_d;
      dn_q    <= dn_d;
    end
  end

  // delta never exceeds the latched distance, so no overshoot past tgt
  always_comb begin
    if (dn_q) begin
      if (delta_q > curI)
        sum = '0;
      else
        sum = {1'b0, curI} - {1'b0, delta_q};
    end else begin
      sum = {1'b0, curI} + {1'b0, delta_q};
    end
    nextO = clamp_p(sum, PERIOD_MIN, PERIOD_MAX);
  end

endmodule

// File: rtl/m3_round_len_calc.sv
// Step-period calculator for motor channel 3: ramps the step length
// toward a button-set target on each sequencer request edge.
module m3_round_len_calc
  import m3_round_len_calc_pkg::*;
#(
  parameter period_t     PERIOD_MIN = 22'd1000,
  parameter period_t     PERIOD_MAX = PERIOD_MAX_DEF,
  parameter period_t     TGT_STEP   = 22'd100_000,
  parameter int unsigned RAMP_SHIFT = 3,
  parameter logic [3:0]  PWR_RESET  = 4'd8
) (
  input  logic        clkI,
  input  logic        rstI,
  input  logic        m3startI,
  input  logic        m3forceStopI,
  input  logic        m3speedINCi,
  input  logic        m3speedDECi,
  input  logic        m3powerINCi,
  input  logic        m3powerDECi,
  input  logic        nextCalc_1i,
  output logic [31:0] dstRoundLenO,
  output logic [3:0]  powerLevelO,
  output logic        calcBusyO,
  output logic        atTargetO,
  output logic        stoppedO
);

  state_e     state_q, state_d;
  period_t    cur_q, cur_d;
  period_t    tgt_q, tgt_d;
  period_t    dst_q, dst_d;
  logic [3:0] pwr_q, pwr_d;
  logic       req_d_q;
  logic       at_tgt_q, at_tgt_d;
  logic       stop_q, stop_d;
  logic       req;
  logic       calc_latch;
  period_t    tgt_eff;
  period_t    ramp_next;

  assign req     = nextCalc_1i & ~req_d_q;
  assign tgt_eff = m3forceStopI ? PERIOD_MAX : tgt_q;

  m3_ramp_step #(
    .PERIOD_MIN (PERIOD_MIN),
    .PERIOD_MAX (PERIOD_MAX),
    .RAMP_SHIFT (RAMP_SHIFT)
  ) u_ramp (
    .clkI   (clkI),
    .rstI   (rstI),
    .latchI (calc_latch),
    .curI   (cur_q),
    .tgtI   (tgt_eff),
    .nextO  (ramp_next)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    dst_d      = dst_q;
    calc_latch = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (m3startI)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (req)
          state_d = S_CALC;
      end
      S_CALC: begin
        calc_latch = 1'b1;
        state_d    = S_APPLY;
      end
      S_APPLY: begin
        cur_d   = ramp_next;
        dst_d   = ramp_next;
        state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
    // stopping the channel aborts any calculation in flight
    if (!m3startI) begin
      state_d = S_IDLE;
      cur_d   = PERIOD_MAX;
      dst_d   = PERIOD_MAX;
    end
  end

  always_comb begin
    tgt_d = tgt_q;
    if (!m3forceStopI) begin
      unique case (1'b1)
        m3speedINCi & ~m3speedDECi:
          tgt_d = (tgt_q < PERIOD_MIN + TGT_STEP) ?
                  PERIOD_MIN : tgt_q - TGT_STEP;
        m3speedDECi & ~m3speedINCi:
          tgt_d = (tgt_q > PERIOD_MAX - TGT_STEP) ?
                  PERIOD_MAX : tgt_q + TGT_STEP;
        default: tgt_d = tgt_q;
      endcase
    end
  end

  always_comb begin
    pwr_d = pwr_q;
    unique case (1'b1)
      m3powerINCi & ~m3powerDECi:
        pwr_d = (pwr_q == 4'd15) ? pwr_q : pwr_q + 4'd1;
      m3powerDECi & ~m3powerINCi:
        pwr_d = (pwr_q == 4'd0) ? pwr_q : pwr_q - 4'd1;
      default: pwr_d = pwr_q;
    endcase
  end

  always_comb begin
    at_tgt_d = cur_q == tgt_q;
    stop_d   = m3forceStopI & (cur_q == PERIOD_MAX);
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      state_q  <= S_IDLE;
      cur_q    <= PERIOD_MAX;
      tgt_q    <= PERIOD_MAX;
      dst_q    <= PERIOD_MAX;
      pwr_q    <= PWR_RESET;
      req_d_q  <= 1'b0;
      at_tgt_q <= 1'b1;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      dst_q    <= dst_d;
      pwr_q    <= pwr_d;
      req_d_q  <= nextCalc_1i;
      at_tgt_q <= at_tgt_d;
      stop_q   <= stop_d;
    end
  end

  assign dstRoundLenO = {10'd0, dst_q};
  assign powerLevelO  = pwr_q;
  assign calcBusyO    = (state_q == S_CALC) || (state_q == S_APPLY);
  assign atTargetO    = at_tgt_q;
  assign stoppedO     = stop_q;

endmodule

// File: tb/tb_m3_round_len_calc.sv
// Directed bench for m3_round_len_calc: ramp, saturation, forceStop,
// power buttons, start abort and synchronous reset.
module tb_m3_round_len_calc;

  localparam int unsigned PMIN = 1000;
  localparam int unsigned PMAX = 4_000_000;

  logic        clkI = 1'b0;
  logic        rstI = 1'b1;
  logic        m3startI = 1'b0;
  logic        m3forceStopI = 1'b0;
  logic        m3speedINCi = 1'b0;
  logic        m3speedDECi = 1'b0;
  logic        m3powerINCi = 1'b0;
  logic        m3powerDECi = 1'b0;
  logic        nextCalc_1i = 1'b0;
  logic [31:0] dstRoundLenO;
  logic [3:0]  powerLevelO;
  logic        calcBusyO;
  logic        atTargetO;
  logic        stoppedO;

  int n_chk = 0;
  int n_err = 0;

  int unsigned m_cur;
  int unsigned m_tgt;
  int unsigned prev;
  int          last_delta;
  logic        done;
  logic        mono_bad;

  m3_round_len_calc dut (
    .clkI         (clkI),
    .rstI         (rstI),
    .m3startI     (m3startI),
    .m3forceStopI (m3forceStopI),
    .m3speedINCi  (m3speedINCi),
    .m3speedDECi  (m3speedDECi),
    .m3powerINCi  (m3powerINCi),
    .m3powerDECi  (m3powerDECi),
    .nextCalc_1i  (nextCalc_1i),
    .dstRoundLenO (dstRoundLenO),
    .powerLevelO  (powerLevelO),
    .calcBusyO    (calcBusyO),
    .atTargetO    (atTargetO),
    .stoppedO     (stoppedO)
  );

  always #5 clkI = ~clkI;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkI);
    #1;
  endtask

  task automatic do_req();
    nextCalc_1i = 1'b1;
    step();
    step();
    step();
    nextCalc_1i = 1'b0;
    step();
  endtask

  task automatic spd(input logic inc, input logic dec);
    m3speedINCi = inc;
    m3speedDECi = dec;
    step();
    m3speedINCi = 1'b0;
    m3speedDECi = 1'b0;
  endtask

  task automatic pwr(input logic inc, input logic dec);
    m3powerINCi = inc;
    m3powerDECi = dec;
    step();
    m3powerINCi = 1'b0;
    m3powerDECi = 1'b0;
  endtask

  function automatic int unsigned nxt(input int unsigned c,
                                      input int unsigned t);
    int unsigned diff, d, r;
    diff = (c > t) ? c - t : t - c;
    d = diff >> 3;
    if (d == 0 && diff != 0) d = 1;
    r = (c > t) ? c - d : c + d;
    if (r < PMIN) r = PMIN;
    if (r > PMAX) r = PMAX;
    return r;
  endfunction

  initial begin
    m3startI = 1'b1;
    step();
    step();
    chk("rst_dst", dstRoundLenO, PMAX);
    chk("rst_pwr", {28'd0, powerLevelO}, 8);
    chk("rst_busy", {31'd0, calcBusyO}, 0);
    chk("rst_attgt", {31'd0, atTargetO}, 1);
    chk("rst_stop", {31'd0, stoppedO}, 0);
    rstI = 1'b0;
    step();
    m_cur = PMAX;
    m_tgt = PMAX;

    do_req();
    chk("idle_req", dstRoundLenO, PMAX);

    spd(1'b1, 1'b0);
    m_tgt = 3_900_000;
    nextCalc_1i = 1'b1;
    step();
    chk("busy1", {31'd0, calcBusyO}, 1);
    step();
    chk("busy2", {31'd0, calcBusyO}, 1);
    chk("dst_hold", dstRoundLenO, PMAX);
    step();
    chk("busy3", {31'd0, calcBusyO}, 0);
    chk("first_step", dstRoundLenO, 3_987_500);
    nextCalc_1i = 1'b0;
    step();
    m_cur = 3_987_500;
    chk("not_at_tgt", {31'd0, atTargetO}, 0);

    for (int i = 0; i < 45; i++) spd(1'b1, 1'b0);
    m_tgt = PMIN;
    prev = dstRoundLenO;
    done = 1'b0;
    mono_bad = 1'b0;
    last_delta = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      do_req();
      m_cur = nxt(m_cur, m_tgt);
      chk("conv", dstRoundLenO, m_cur);
      if (dstRoundLenO > prev || dstRoundLenO < PMIN) mono_bad = 1'b1;
      last_delta = int'(prev) - int'(dstRoundLenO);
      prev = dstRoundLenO;
      if (dstRoundLenO == PMIN) done = 1'b1;
    end
    chk("conv_done", {31'd0, done}, 1);
    chk("conv_mono", {31'd0, mono_bad}, 0);
    chk("last_delta", last_delta, 1);
    chk("at_tgt", {31'd0, atTargetO}, 1);

    m3forceStopI = 1'b1;
    step();
    spd(1'b0, 1'b1);
    spd(1'b0, 1'b1);
    spd(1'b1, 1'b0);
    done = 1'b0;
    mono_bad = 1'b0;
    prev = dstRoundLenO;
    for (int i = 0; i < 400 && !done; i++) begin
      if (i == 5) spd(1'b0, 1'b1);
      do_req();
      m_cur = nxt(m_cur, PMAX);
      chk("fs_ramp", dstRoundLenO, m_cur);
      if (dstRoundLenO < prev) mono_bad = 1'b1;
      prev = dstRoundLenO;
      if (dstRoundLenO == PMAX) done = 1'b1;
    end
    chk("fs_done", {31'd0, done}, 1);
    chk("fs_mono", {31'd0, mono_bad}, 0);
    chk("stopped", {31'd0, stoppedO}, 1);

    m3forceStopI = 1'b0;
    step();
    chk("unstopped", {31'd0, stoppedO}, 0);
    do_req();
    m_cur = nxt(m_cur, m_tgt);
    chk("resume", dstRoundLenO, 3_500_125);

    for (int i = 0; i < 10; i++) pwr(1'b1, 1'b0);
    chk("pwr_max", {28'd0, powerLevelO}, 15);
    pwr(1'b1, 1'b1);
    chk("pwr_both", {28'd0, powerLevelO}, 15);
    pwr(1'b0, 1'b1);
    chk("pwr_dec1", {28'd0, powerLevelO}, 14);
    for (int i = 0; i < 19; i++) pwr(1'b0, 1'b1);
    chk("pwr_min", {28'd0, powerLevelO}, 0);
    pwr(1'b1, 1'b1);
    chk("pwr_both0", {28'd0, powerLevelO}, 0);

    nextCalc_1i = 1'b1;
    step();
    m3startI = 1'b0;
    step();
    chk("abort_dst", dstRoundLenO, PMAX);
    nextCalc_1i = 1'b0;
    step();
    m3startI = 1'b1;
    step();
    step();
    step();
    chk("abort_keep", dstRoundLenO, PMAX);
    chk("abort_busy", {31'd0, calcBusyO}, 0);
    m_cur = PMAX;

    nextCalc_1i = 1'b1;
    step();
    step();
    step();
    chk("long_first", dstRoundLenO, 3_500_125);
    for (int i = 0; i < 20; i++) step();
    chk("long_once", dstRoundLenO, 3_500_125);
    nextCalc_1i = 1'b0;
    step();
    m_cur = 3_500_125;

    do_req();
    m_cur = nxt(m_cur, m_tgt);
    chk("pre_rst", dstRoundLenO, m_cur);
    m3powerINCi = 1'b1;
    step();
    m3powerINCi = 1'b0;
    rstI = 1'b1;
    step();
    rstI = 1'b0;
    chk("rst2_dst", dstRoundLenO, PMAX);
    chk("rst2_pwr", {28'd0, powerLevelO}, 8);
    chk("rst2_attgt", {31'd0, atTargetO}, 1);
    chk("rst2_busy", {31'd0, calcBusyO}, 0);
    step();
    do_req();
    chk("rst2_tgt", dstRoundLenO, PMAX);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
